// File: rtl/i2c_target.sv
// I2C target endpoint: 8 x 8-bit register file behind an auto-incrementing pointer.
// Define I2C_TARGET_GLITCH_FILTER_EN to add 3-sample filters on the synchronised SCL/SDA.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter logic [7:0] RST_VAL  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  tri         sda,
  output logic       busy,
  output logic       wr_tick,
  output logic [2:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_s, sda_s, scl_f, sda_f, scl_d, sda_d;
  logic        scl_rise, scl_fall, start, stop;
  logic [7:0]  shift;
  logic [3:0]  cnt;
  logic [2:0]  ptr;
  logic        first, ack_ok, sda_oe;
  logic [7:0]  regs [8];
  logic [7:0]  reg_ptr;
  logic        addr_match, bus_ev;
  logic        shift_in, byte_wr, load_rd, shift_out, ack_sample, oe_nxt, busy_nxt;

  // Synchronisers reset to the idle-bus level so release from reset makes no phantom edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
    end
  end
  assign scl_s = scl_sync[1];
  assign sda_s = sda_sync[1];

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_hist, sda_hist;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_s};
      sda_hist <= {sda_hist[0], sda_s};
      if (&{scl_hist, scl_s}) scl_f <= 1'b1;
      else if (~|{scl_hist, scl_s}) scl_f <= 1'b0;
      if (&{sda_hist, sda_s}) sda_f <= 1'b1;
      else if (~|{sda_hist, sda_s}) sda_f <= 1'b0;
    end
  end
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise   = scl_f & ~scl_d;
  assign scl_fall   = ~scl_f & scl_d;
  assign start      = scl_f & scl_d & sda_d & ~sda_f;
  assign stop       = scl_f & scl_d & ~sda_d & sda_f;
  assign bus_ev     = start | stop;
  assign addr_match = (shift[7:1] == DEV_ADDR);
  assign reg_ptr    = regs[ptr];
  assign rd_data    = regs[rd_addr];
  assign sda        = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start)     state_nxt = ADDR;
    else if (stop) state_nxt = IDLE;
    else if (scl_fall) begin
      case (state)
        ADDR:     if (cnt == 4'd8) state_nxt = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: state_nxt = shift[0] ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (cnt == 4'd8) state_nxt = WR_ACK;
        WR_ACK:   state_nxt = WR_BYTE;
        RD_BYTE:  if (cnt == 4'd7) state_nxt = RD_ACK;
        RD_ACK:   state_nxt = ack_ok ? RD_BYTE : IGNORE;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    shift_in   = !bus_ev && scl_rise && (state == ADDR || state == WR_BYTE) && (cnt != 4'd8);
    byte_wr    = shift_in && (state == WR_BYTE) && (cnt == 4'd7);
    load_rd    = !bus_ev && scl_fall && ((state == ADDR_ACK && shift[0]) || (state == RD_ACK && ack_ok));
    shift_out  = !bus_ev && scl_fall && (state == RD_BYTE) && (cnt != 4'd7);
    ack_sample = !bus_ev && scl_rise && (state == RD_ACK);
    busy_nxt   = busy;
    if (start)     busy_nxt = 1'b1;
    else if (stop) busy_nxt = 1'b0;
    else if (scl_fall && state == ADDR && cnt == 4'd8 && !addr_match) busy_nxt = 1'b0;
    oe_nxt = sda_oe;
    if (bus_ev) oe_nxt = 1'b0;
    else if (scl_fall) begin
      case (state)
        ADDR:             if (cnt == 4'd8) oe_nxt = addr_match;
        ADDR_ACK, RD_ACK: oe_nxt = load_rd ? ~reg_ptr[7] : 1'b0;
        WR_BYTE:          if (cnt == 4'd8) oe_nxt = 1'b1;
        RD_BYTE:          oe_nxt = (cnt == 4'd7) ? 1'b0 : ~shift[6];
        default:          oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift   <= 8'h00;
      cnt     <= 4'd0;
      ptr     <= RST_VAL[2:0];
      first   <= 1'b0;
      ack_ok  <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_tick <= 1'b0;
      wr_addr <= 3'd0;
      wr_data <= RST_VAL;
      for (int i = 0; i < 8; i++) regs[i] <= RST_VAL;
    end else begin
      wr_tick <= 1'b0;
      sda_oe  <= oe_nxt;
      busy    <= busy_nxt;
      if (start) begin
        shift <= 8'h00;
        cnt   <= 4'd0;
      end else if (!stop) begin
        if (shift_in) begin
          shift <= {shift[6:0], sda_f};
          cnt   <= cnt + 4'd1;
        end
        // The first data byte after a write address only sets the pointer.
        if (byte_wr) begin
          if (first) begin
            ptr   <= {shift[1:0], sda_f};
            first <= 1'b0;
          end else begin
            regs[ptr] <= {shift[6:0], sda_f};
            wr_tick   <= 1'b1;
            wr_addr   <= ptr;
            wr_data   <= {shift[6:0], sda_f};
            ptr       <= ptr + 3'd1;
          end
        end
        if (scl_fall && (state == ADDR_ACK || state == WR_ACK)) cnt <= 4'd0;
        if (scl_fall && state == ADDR_ACK) first <= 1'b1;
        if (load_rd) begin
          shift <= reg_ptr;
          cnt   <= 4'd0;
        end
        if (shift_out) begin
          shift <= {shift[6:0], 1'b0};
          cnt   <= cnt + 4'd1;
        end
        if (ack_sample) begin
          ack_ok <= ~sda_f;
          if (!sda_f) ptr <= ptr + 3'd1;
        end
      end
    end
  end

endmodule
